// File: rtl/mmu_pkg.sv
// Shared MMU types for the Sv39 page-table walker: walker state, PTE layout
// and the VPN slice selector.
package mmu_pkg;

    localparam int PTW_LEVELS = 3;
    localparam int VPN_SEG_W  = 9;
    localparam int VPN_W      = PTW_LEVELS * VPN_SEG_W;

    typedef enum logic [1:0] {
        PTW_IDLE = 2'd0,
        PTW_REQ  = 2'd1,
        PTW_WAIT = 2'd2,
        PTW_DONE = 2'd3
    } ptw_state_t;

    typedef struct packed {
        logic [9:0]  reserved;
        logic [43:0] ppn;
        logic [1:0]  rsw;
        logic        d;
        logic        a;
        logic        g;
        logic        u;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } sv39_pte_t;

    function automatic logic [VPN_SEG_W-1:0] vpn_seg(input logic [VPN_W-1:0] vpn,
                                                     input logic [1:0]       level);
        case (level)
            2'd2:    return vpn[3*VPN_SEG_W-1:2*VPN_SEG_W];
            2'd1:    return vpn[2*VPN_SEG_W-1:VPN_SEG_W];
            default: return vpn[VPN_SEG_W-1:0];
        endcase
    endfunction

endpackage

// File: rtl/ptw_pte_check.sv
// Combinational Sv39 PTE decode: leaf detection, fault detection, next-level PPN.
// Optional PTW_AD_CHECK_EN: leaf with A=0, or store to a leaf with D=0, faults.
module ptw_pte_check
    import mmu_pkg::*;
#(
    parameter int PPN_W = 20
) (
    input  sv39_pte_t        pte,
    input  logic [1:0]       level,
    input  logic             store,
    output logic             leaf,
    output logic             error,
    output logic [PPN_W-1:0] next_ppn
);

    logic invalid;
    logic misaligned;
    logic ad_fault;
    logic unused_pte_bits;

    always_comb begin
        leaf     = pte.r | pte.x;
        // PPN bits beyond the physical address width must be zero
        invalid  = !pte.v || (!pte.r && pte.w) || (pte.ppn[43:PPN_W] != '0);
        case (level)
            2'd2:    misaligned = (pte.ppn[2*VPN_SEG_W-1:0] != '0);
            2'd1:    misaligned = (pte.ppn[VPN_SEG_W-1:0] != '0);
            default: misaligned = 1'b0;
        endcase
`ifdef PTW_AD_CHECK_EN
        ad_fault = !pte.a || (store && !pte.d);
`else
        ad_fault = 1'b0;
`endif
        error    = invalid || (leaf ? (misaligned || ad_fault) : (level == 2'd0));
        next_ppn = pte.ppn[PPN_W-1:0];
    end

    assign unused_pte_bits = ^{pte.reserved, pte.rsw, pte.g, pte.u, pte.a, pte.d, store};

endmodule

// File: rtl/ptw_sv39_walker.sv
// Sv39 hardware page-table walker answering TLB miss requests, plus sfence.vma
// TLB invalidate pulse. A/D checking is enabled by defining PTW_AD_CHECK_EN.
//
// state | meaning
// IDLE  | ready for a TLB miss request
// REQ   | PTE read request presented to memory, held until accepted
// WAIT  | waiting for the PTE; decoded in the cycle it arrives
// DONE  | one-cycle response to the TLB
module ptw_sv39_walker
    import mmu_pkg::*;
#(
    parameter int PA_W  = 32,
    parameter int PTE_W = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              tlb_req_valid_i,
    input  logic [VPN_W-1:0]  tlb_req_vpn_i,
    input  logic [1:0]        tlb_req_prv_i,
    input  logic              tlb_req_store_i,
    input  logic              tlb_req_fetch_i,
    output logic              tlb_req_ready_o,
    output logic              tlb_resp_valid_o,
    output logic              tlb_resp_error_o,
    output logic [PA_W-13:0]  tlb_resp_pte_ppn_o,
    output logic [1:0]        tlb_resp_pte_rfs_o,
    output logic              tlb_resp_pte_d_o,
    output logic              tlb_resp_pte_a_o,
    output logic              tlb_resp_pte_g_o,
    output logic              tlb_resp_pte_u_o,
    output logic              tlb_resp_pte_x_o,
    output logic              tlb_resp_pte_w_o,
    output logic              tlb_resp_pte_r_o,
    output logic              tlb_resp_pte_v_o,
    output logic [1:0]        tlb_resp_level_o,
    output logic              tlb_invalidate_o,
    input  logic [PA_W-13:0]  csr_satp_ppn_i,
    input  logic              csr_flush_i,
    output logic              mem_req_valid_o,
    output logic [PA_W-1:0]   mem_req_addr_o,
    input  logic              mem_req_ready_i,
    input  logic              mem_resp_valid_i,
    input  logic [PTE_W-1:0]  mem_resp_data_i
);

    localparam int PPN_W = PA_W - 12;

    ptw_state_t       state_q, state_d;
    logic [VPN_W-1:0] vpn_q;
    logic [1:0]       prv_q;
    logic             store_q;
    logic             fetch_q;
    logic [1:0]       level_q;
    logic [PPN_W-1:0] ppn_q;
    logic             restart_q;
    logic             invalidate_q;

    logic             resp_error_q;
    logic [PPN_W-1:0] resp_ppn_q;
    logic [1:0]       resp_rsw_q;
    logic [7:0]       resp_flags_q;
    logic [1:0]       resp_level_q;

    sv39_pte_t        pte;
    logic             chk_leaf;
    logic             chk_error;
    logic [PPN_W-1:0] chk_next_ppn;
    logic             walk_abort;
    logic             unused_req;

    assign pte        = sv39_pte_t'(mem_resp_data_i);
    // a flush seen during this attempt (earlier or right now) discards the PTE
    assign walk_abort = restart_q || csr_flush_i;
    assign unused_req = ^{prv_q, fetch_q};

    ptw_pte_check #(.PPN_W(PPN_W)) u_pte_check (
        .pte      (pte),
        .level    (level_q),
        .store    (store_q),
        .leaf     (chk_leaf),
        .error    (chk_error),
        .next_ppn (chk_next_ppn)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= PTW_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            PTW_IDLE: if (tlb_req_valid_i) state_d = PTW_REQ;
            PTW_REQ:  if (mem_req_ready_i) state_d = PTW_WAIT;
            PTW_WAIT: begin
                if (mem_resp_valid_i) begin
                    if (walk_abort)                  state_d = PTW_REQ;
                    else if (chk_error || chk_leaf)  state_d = PTW_DONE;
                    else                             state_d = PTW_REQ;
                end
            end
            PTW_DONE: state_d = PTW_IDLE;
            default:  state_d = PTW_IDLE;
        endcase
    end

    always_comb begin
        tlb_req_ready_o  = (state_q == PTW_IDLE);
        mem_req_valid_o  = (state_q == PTW_REQ);
        tlb_resp_valid_o = (state_q == PTW_DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vpn_q        <= '0;
            prv_q        <= '0;
            store_q      <= 1'b0;
            fetch_q      <= 1'b0;
            level_q      <= 2'd2;
            ppn_q        <= '0;
            restart_q    <= 1'b0;
            invalidate_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_ppn_q   <= '0;
            resp_rsw_q   <= '0;
            resp_flags_q <= '0;
            resp_level_q <= '0;
        end else begin
            invalidate_q <= csr_flush_i;
            case (state_q)
                PTW_IDLE: begin
                    if (tlb_req_valid_i) begin
                        vpn_q   <= tlb_req_vpn_i;
                        prv_q   <= tlb_req_prv_i;
                        store_q <= tlb_req_store_i;
                        fetch_q <= tlb_req_fetch_i;
                        level_q <= 2'd2;
                        ppn_q   <= csr_satp_ppn_i;
                    end
                end
                PTW_REQ: begin
                    if (csr_flush_i) restart_q <= 1'b1;
                end
                PTW_WAIT: begin
                    if (mem_resp_valid_i) begin
                        if (walk_abort) begin
                            restart_q <= 1'b0;
                            level_q   <= 2'd2;
                            ppn_q     <= csr_satp_ppn_i;
                        end else if (chk_error || chk_leaf) begin
                            resp_error_q <= chk_error;
                            resp_ppn_q   <= chk_next_ppn;
                            resp_rsw_q   <= pte.rsw;
                            resp_flags_q <= {pte.d, pte.a, pte.g, pte.u,
                                             pte.x, pte.w, pte.r, pte.v};
                            resp_level_q <= level_q;
                        end else begin
                            ppn_q   <= chk_next_ppn;
                            level_q <= level_q - 2'd1;
                        end
                    end else if (csr_flush_i) begin
                        restart_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req_addr_o     = {ppn_q, vpn_seg(vpn_q, level_q), 3'b000};
    assign tlb_invalidate_o   = invalidate_q;
    assign tlb_resp_error_o   = resp_error_q;
    assign tlb_resp_pte_ppn_o = resp_ppn_q;
    assign tlb_resp_pte_rfs_o = resp_rsw_q;
    assign tlb_resp_pte_d_o   = resp_flags_q[7];
    assign tlb_resp_pte_a_o   = resp_flags_q[6];
    assign tlb_resp_pte_g_o   = resp_flags_q[5];
    assign tlb_resp_pte_u_o   = resp_flags_q[4];
    assign tlb_resp_pte_x_o   = resp_flags_q[3];
    assign tlb_resp_pte_w_o   = resp_flags_q[2];
    assign tlb_resp_pte_r_o   = resp_flags_q[1];
    assign tlb_resp_pte_v_o   = resp_flags_q[0];
    assign tlb_resp_level_o   = resp_level_q;

endmodule

// File: tb/tb_ptw_sv39_walker.sv
// Self-checking bench for ptw_sv39_walker: table of walks with a zero/stalled
// memory responder, scoreboarded responses, plus flush and reset sequences.
module tb_ptw_sv39_walker;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        tlb_req_valid_i;
    logic [26:0] tlb_req_vpn_i;
    logic [1:0]  tlb_req_prv_i;
    logic        tlb_req_store_i;
    logic        tlb_req_fetch_i;
    logic        tlb_req_ready_o;
    logic        tlb_resp_valid_o;
    logic        tlb_resp_error_o;
    logic [19:0] tlb_resp_pte_ppn_o;
    logic [1:0]  tlb_resp_pte_rfs_o;
    logic        tlb_resp_pte_d_o, tlb_resp_pte_a_o, tlb_resp_pte_g_o, tlb_resp_pte_u_o;
    logic        tlb_resp_pte_x_o, tlb_resp_pte_w_o, tlb_resp_pte_r_o, tlb_resp_pte_v_o;
    logic [1:0]  tlb_resp_level_o;
    logic        tlb_invalidate_o;
    logic [19:0] csr_satp_ppn_i;
    logic        csr_flush_i;
    logic        mem_req_valid_o;
    logic [31:0] mem_req_addr_o;
    logic        mem_req_ready_i;
    logic        mem_resp_valid_i;
    logic [63:0] mem_resp_data_i;

    ptw_sv39_walker #(.PA_W(32), .PTE_W(64)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .tlb_req_valid_i    (tlb_req_valid_i),
        .tlb_req_vpn_i      (tlb_req_vpn_i),
        .tlb_req_prv_i      (tlb_req_prv_i),
        .tlb_req_store_i    (tlb_req_store_i),
        .tlb_req_fetch_i    (tlb_req_fetch_i),
        .tlb_req_ready_o    (tlb_req_ready_o),
        .tlb_resp_valid_o   (tlb_resp_valid_o),
        .tlb_resp_error_o   (tlb_resp_error_o),
        .tlb_resp_pte_ppn_o (tlb_resp_pte_ppn_o),
        .tlb_resp_pte_rfs_o (tlb_resp_pte_rfs_o),
        .tlb_resp_pte_d_o   (tlb_resp_pte_d_o),
        .tlb_resp_pte_a_o   (tlb_resp_pte_a_o),
        .tlb_resp_pte_g_o   (tlb_resp_pte_g_o),
        .tlb_resp_pte_u_o   (tlb_resp_pte_u_o),
        .tlb_resp_pte_x_o   (tlb_resp_pte_x_o),
        .tlb_resp_pte_w_o   (tlb_resp_pte_w_o),
        .tlb_resp_pte_r_o   (tlb_resp_pte_r_o),
        .tlb_resp_pte_v_o   (tlb_resp_pte_v_o),
        .tlb_resp_level_o   (tlb_resp_level_o),
        .tlb_invalidate_o   (tlb_invalidate_o),
        .csr_satp_ppn_i     (csr_satp_ppn_i),
        .csr_flush_i        (csr_flush_i),
        .mem_req_valid_o    (mem_req_valid_o),
        .mem_req_addr_o     (mem_req_addr_o),
        .mem_req_ready_i    (mem_req_ready_i),
        .mem_resp_valid_i   (mem_resp_valid_i),
        .mem_resp_data_i    (mem_resp_data_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct packed {
        logic [19:0]      satp;
        logic [26:0]      vpn;
        logic             store;
        int               n;
        int               stall;
        int               flush_idx;   // -1 none, -2 with request, k: in WAIT of read k
        logic [5:0][63:0] pte;
        logic [5:0][31:0] addr;
        logic             err;
        logic [1:0]       lvl;
        logic [19:0]      ppn;
        logic [9:0]       flags;
        int               lat;
    } vec_t;

    typedef struct packed {
        logic        err;
        logic [1:0]  lvl;
        logic [19:0] ppn;
        logic [9:0]  flags;
        int          lat;
    } exp_t;

    vec_t        vecs[$];
    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    logic [63:0] pte_q[$];
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [19:0] satp, input logic [26:0] vpn,
                                input logic store, input int n, input int stall,
                                input int fidx, input logic err, input logic [1:0] lvl,
                                input logic [19:0] ppn, input logic [9:0] flags,
                                input int lat);
        vec_t v;
        v = '0;
        v.satp = satp; v.vpn = vpn; v.store = store; v.n = n; v.stall = stall;
        v.flush_idx = fidx; v.err = err; v.lvl = lvl; v.ppn = ppn; v.flags = flags;
        v.lat = lat;
        return v;
    endfunction

    task automatic check_resp(input int lat);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_resp actual=1 expected=0 (t=%0t)", $time);
        end else begin
            e = exp_q.pop_front();
            chk("resp_error", tlb_resp_error_o, e.err);
            chk("resp_level", tlb_resp_level_o, e.lvl);
            chk("resp_latency", lat, e.lat);
            if (!e.err) begin
                chk("resp_ppn", tlb_resp_pte_ppn_o, e.ppn);
                chk("resp_flags", {tlb_resp_pte_rfs_o, tlb_resp_pte_d_o, tlb_resp_pte_a_o,
                                   tlb_resp_pte_g_o, tlb_resp_pte_u_o, tlb_resp_pte_x_o,
                                   tlb_resp_pte_w_o, tlb_resp_pte_r_o, tlb_resp_pte_v_o},
                    e.flags);
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   t0, k, stall_left, n_seen;
        logic do_resp, fl_done, fl_prev;
        exp_t e;
        addr_q.delete();
        pte_q.delete();
        for (int i = 0; i < v.n; i++) begin
            addr_q.push_back(v.addr[i]);
            pte_q.push_back(v.pte[i]);
        end
        e.err = v.err; e.lvl = v.lvl; e.ppn = v.ppn; e.flags = v.flags; e.lat = v.lat;
        exp_q.push_back(e);
        stall_left = v.stall;
        @(posedge clk_i); #1;
        tlb_req_valid_i = 1'b1;
        tlb_req_vpn_i   = v.vpn;
        tlb_req_store_i = v.store;
        tlb_req_prv_i   = 2'd1;
        csr_satp_ppn_i  = v.satp;
        csr_flush_i     = (v.flush_idx == -2);
        mem_req_ready_i = (stall_left == 0);
        t0 = cyc;
        @(negedge clk_i);
        chk("req_ready", tlb_req_ready_o, 1'b1);
        k = 0; do_resp = 1'b0; fl_done = 1'b0; n_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk_i); #1;
            fl_prev          = csr_flush_i;
            tlb_req_valid_i  = 1'b0;
            csr_flush_i      = 1'b0;
            mem_resp_valid_i = 1'b0;
            mem_req_ready_i  = (stall_left == 0);
            if (do_resp) begin
                if (k - 1 == v.flush_idx && !fl_done) begin
                    csr_flush_i = 1'b1;
                    fl_done     = 1'b1;
                end else begin
                    mem_resp_valid_i = 1'b1;
                    mem_resp_data_i  = pte_q.pop_front();
                    do_resp          = 1'b0;
                end
            end
            @(negedge clk_i);
            chk("invalidate", tlb_invalidate_o, fl_prev);
            if (mem_req_valid_o) begin
                if (addr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_mem_req actual=%h expected=none", mem_req_addr_o);
                end else begin
                    chk("mem_addr", mem_req_addr_o, addr_q[0]);
                    if (mem_req_ready_i) begin
                        void'(addr_q.pop_front());
                        k++;
                        do_resp = 1'b1;
                    end else if (stall_left > 0) begin
                        stall_left--;
                    end
                end
            end
            if (tlb_resp_valid_o) begin
                n_seen++;
                check_resp(cyc - t0);
            end
        end
        chk("resp_count", n_seen, 1);
        chk("mem_reqs_left", addr_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        vec_t v;
        rst_i = 1'b1;
        tlb_req_valid_i = 0; tlb_req_vpn_i = '0; tlb_req_prv_i = '0;
        tlb_req_store_i = 0; tlb_req_fetch_i = 0; csr_satp_ppn_i = '0;
        csr_flush_i = 0; mem_req_ready_i = 0; mem_resp_valid_i = 0; mem_resp_data_i = '0;

        // 4 KiB leaf through two non-leaf levels
        v = mk(20'h80000, 27'h0000001, 0, 3, 0, -1, 0, 2'd0, 20'h12345, 10'h0CF, 7);
        v.addr[0] = 32'h80000000; v.pte[0] = 64'h20000401;
        v.addr[1] = 32'h80001000; v.pte[1] = 64'h20000801;
        v.addr[2] = 32'h80002008; v.pte[2] = 64'h048D14CF;
        vecs.push_back(v);
        // 1 GiB leaf
        v = mk(20'h80000, 27'h4000000, 0, 1, 0, -1, 0, 2'd2, 20'h80000, 10'h0CF, 3);
        v.addr[0] = 32'h80000800; v.pte[0] = 64'h00000000200000CF;
        vecs.push_back(v);
        // misaligned 1 GiB leaf
        v = mk(20'h80000, 27'h0, 0, 1, 0, -1, 1, 2'd2, 20'h0, 10'h0, 3);
        v.addr[0] = 32'h80000000; v.pte[0] = 64'h200004CF;
        vecs.push_back(v);
        // V=0 at level 1
        v = mk(20'h80000, 27'h003FE00, 0, 2, 0, -1, 1, 2'd1, 20'h0, 10'h0, 5);
        v.addr[0] = 32'h80000000; v.pte[0] = 64'h20000401;
        v.addr[1] = 32'h80001FF8; v.pte[1] = 64'h0;
        vecs.push_back(v);
        // 2 MiB leaf, all flags set
        v = mk(20'h80000, 27'h0, 0, 2, 0, -1, 0, 2'd1, 20'h00400, 10'h0FF, 5);
        v.addr[0] = 32'h80000000; v.pte[0] = 64'h20000401;
        v.addr[1] = 32'h80001000; v.pte[1] = 64'h001000FF;
        vecs.push_back(v);
        // reserved PPN bit 30 set
        v = mk(20'h80000, 27'h0, 0, 1, 0, -1, 1, 2'd2, 20'h0, 10'h0, 3);
        v.addr[0] = 32'h80000000; v.pte[0] = 64'h400000CF;
        vecs.push_back(v);
        // W without R
        v = mk(20'h80000, 27'h0, 0, 1, 0, -1, 1, 2'd2, 20'h0, 10'h0, 3);
        v.addr[0] = 32'h80000000; v.pte[0] = 64'h20000005;
        vecs.push_back(v);
        // non-leaf at level 0
        v = mk(20'h80000, 27'h0, 0, 3, 0, -1, 1, 2'd0, 20'h0, 10'h0, 7);
        v.addr[0] = 32'h80000000; v.pte[0] = 64'h20000401;
        v.addr[1] = 32'h80001000; v.pte[1] = 64'h20000801;
        v.addr[2] = 32'h80002000; v.pte[2] = 64'h20000C01;
        vecs.push_back(v);
        // store to leaf with D=0
`ifdef PTW_AD_CHECK_EN
        v = mk(20'h80000, 27'h0, 1, 1, 0, -1, 1, 2'd2, 20'h80000, 10'h04F, 3);
`else
        v = mk(20'h80000, 27'h0, 1, 1, 0, -1, 0, 2'd2, 20'h80000, 10'h04F, 3);
`endif
        v.addr[0] = 32'h80000000; v.pte[0] = 64'h2000004F;
        vecs.push_back(v);
        // memory stalls the first request 3 cycles
        v = mk(20'h80000, 27'h4000000, 0, 1, 3, -1, 0, 2'd2, 20'h80000, 10'h0CF, 6);
        v.addr[0] = 32'h80000800; v.pte[0] = 64'h200000CF;
        vecs.push_back(v);
        // flush in WAIT at level 1: in-flight leaf discarded, walk restarts
        v = mk(20'h80000, 27'h0000001, 0, 5, 0, 1, 0, 2'd0, 20'h12345, 10'h0CF, 12);
        v.addr[0] = 32'h80000000; v.pte[0] = 64'h20000401;
        v.addr[1] = 32'h80001000; v.pte[1] = 64'h048D14CF;
        v.addr[2] = 32'h80000000; v.pte[2] = 64'h20000401;
        v.addr[3] = 32'h80001000; v.pte[3] = 64'h20000801;
        v.addr[4] = 32'h80002008; v.pte[4] = 64'h048D14CF;
        vecs.push_back(v);
        // other satp, top VPN, RSW bits
        v = mk(20'h0ABCD, 27'h7FFFFFF, 0, 1, 0, -1, 0, 2'd2, 20'h40000, 10'h2CB, 3);
        v.addr[0] = 32'h0ABCDFF8; v.pte[0] = 64'h100002CB;
        vecs.push_back(v);
        // flush in the same cycle as the request handshake
        v = mk(20'h80000, 27'h4000000, 0, 1, 0, -2, 0, 2'd2, 20'h80000, 10'h0CF, 3);
        v.addr[0] = 32'h80000800; v.pte[0] = 64'h200000CF;
        vecs.push_back(v);

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_req_ready", tlb_req_ready_o, 1'b1);
        chk("rst_mem_req_valid", mem_req_valid_o, 1'b0);
        chk("rst_mem_req_addr", mem_req_addr_o, 32'h0);
        chk("rst_resp_valid", tlb_resp_valid_o, 1'b0);
        chk("rst_invalidate", tlb_invalidate_o, 1'b0);
        chk("rst_resp_fields", {tlb_resp_error_o, tlb_resp_pte_ppn_o, tlb_resp_level_o}, '0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        // reset asserted while waiting for a PTE
        @(posedge clk_i); #1;
        tlb_req_valid_i = 1'b1; tlb_req_vpn_i = '0; csr_satp_ppn_i = 20'h80000;
        mem_req_ready_i = 1'b1;
        @(posedge clk_i); #1;
        tlb_req_valid_i = 1'b0;
        chk("rstw_in_req", mem_req_valid_o, 1'b1);
        @(posedge clk_i); #1;
        chk("rstw_in_wait", {tlb_req_ready_o, mem_req_valid_o}, 2'b00);
        rst_i = 1'b1;
        #1;
        chk("rstw_ready", tlb_req_ready_o, 1'b1);
        chk("rstw_mem_valid", mem_req_valid_o, 1'b0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        mem_resp_valid_i = 1'b1; mem_resp_data_i = 64'h200000CF;
        @(posedge clk_i); #1;
        mem_resp_valid_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            chk("rstw_no_resp", tlb_resp_valid_o, 1'b0);
            chk("rstw_idle", {tlb_req_ready_o, mem_req_valid_o}, 2'b10);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ptw_sv39_walker.md
# ptw_sv39_walker

Hardware page-table walker serving TLB refills in the Lagarto MMU; the responder end of the TLB→PTW request/response interface.
- Accepts one miss request (27-bit VPN) at a time.
- Walks the Sv39 table from `satp` through a single-outstanding memory read port.
- Returns the leaf PTE, its level, or an error.
- Also generates the TLB invalidate pulse on `sfence.vma`.

## Interface
Parameters:
- `PA_W`, 32: physical address width; PPN is `PA_W-12` = 20 bits.
- `PTE_W`, 64: PTE / memory data width.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `tlb_req_valid_i` in 1: miss request valid.
- `tlb_req_vpn_i` in 27: VPN[2:0] = {[26:18],[17:9],[8:0]}.
- `tlb_req_prv_i` in 2: privilege of the access; informational, held in request register.
- `tlb_req_store_i` in 1: store access.
- `tlb_req_fetch_i` in 1: instruction fetch.
- `tlb_req_ready_o` out 1: walker idle, request accepted on valid&ready.
- `tlb_resp_valid_o` out 1: one-cycle response pulse; no backpressure.
- `tlb_resp_error_o` out 1: page fault / access error.
- `tlb_resp_pte_ppn_o` out 20: leaf PPN.
- `tlb_resp_pte_rfs_o` out 2: PTE RSW bits [9:8].
- `tlb_resp_pte_{d,a,g,u,x,w,r,v}_o` out 1 each: PTE flags [7:0].
- `tlb_resp_level_o` out 2: leaf level; 2 = 1 GiB, 1 = 2 MiB, 0 = 4 KiB.
- `tlb_invalidate_o` out 1: one-cycle TLB flush pulse.
- `csr_satp_ppn_i` in 20: root table PPN.
- `csr_flush_i` in 1: `sfence.vma` pulse.
- `mem_req_valid_o` out 1: PTE read request.
- `mem_req_addr_o` out 32: PTE physical address.
- `mem_req_ready_i` in 1: memory accepts request.
- `mem_resp_valid_i` in 1: PTE data valid.
- `mem_resp_data_i` in 64: PTE.

## Operation
FSM states: IDLE, REQ, WAIT, DONE.

- **IDLE:** `tlb_req_ready_o`=1.
  - On handshake, register vpn/prv/store/fetch.
  - Load `level`=2 and `ppn`=`csr_satp_ppn_i`, then go to REQ.
- **REQ:** `mem_req_valid_o`=1 and `mem_req_addr_o`={ppn, vpn[level], 3'b000}.
  - Valid and address are held stable until `mem_req_ready_i`, then go to WAIT.
- **WAIT:** on `mem_resp_valid_i`, decode the PTE in the same cycle:
  - V=0, or (R=0 and W=1), or PTE[53:30]≠0: error, go to DONE.
  - Leaf (R or X): if level>0 and the low PPN slices for that level are ≠0 (misaligned superpage), error; else success. Go to DONE.
  - Non-leaf with level=0: error, go to DONE.
  - Non-leaf otherwise: ppn=PTE[29:10], level−1, go to REQ.
- **DONE:** `tlb_resp_valid_o`=1 for one cycle with the registered PTE fields and level, then go to IDLE.
  - On error, the PPN/flag outputs are don't-care, and `level` reports the faulting level.

Flush handling:
- `csr_flush_i` produces `tlb_invalidate_o` on the next cycle, in every state.
- Flush during REQ or WAIT sets `restart`. The outstanding memory response, if any, is consumed and discarded.
- The walk then restarts at level 2 from the current `csr_satp_ppn_i`. No response is emitted for the aborted attempt.
- Flush in DONE does not cancel the response.
- Flush in the same cycle as the IDLE request handshake: the request is accepted and walks normally.

## Timing
- Reset values:
  - `tlb_req_ready_o`=1 (state IDLE).
  - All other outputs 0.
  - `level`=2, `ppn`=0, `restart`=0.
- All outputs are driven from registers or the state decode; none combinationally depend on inputs.
- Latency with zero-wait memory (ready=1, response one cycle after handshake), request accepted at cycle T:
  - 1 GiB leaf: `tlb_resp_valid_o` at T+3.
  - 2 MiB leaf: at T+5.
  - 4 KiB leaf: at T+7.
- Each level adds 2 cycles plus memory stalls.
- At most one memory request outstanding; `mem_resp_valid_i` outside WAIT is ignored.

## Configuration
- `PTW_AD_CHECK_EN` defined: a leaf with A=0, or with `store`=1 and D=0, returns error (software-managed A/D).
- Not defined: A and D are passed through unchecked.

## Structure
- `mmu_pkg` gains:
  - `ptw_state_t`.
  - `sv39_pte_t` packed struct (reserved[63:54], ppn[53:10], rsw, d, a, g, u, x, w, r, v).
  - Constants `PTW_LEVELS`=3 and `VPN_SEG_W`=9.
- One combinational sub-module, `ptw_pte_check`: PTE plus level plus store in; leaf, error and next_ppn out.

## Test plan
- satp=0x80000, vpn=0x0000001, memory returns non-leaf, non-leaf, then leaf PPN 0x12345 with RWXV=1 and AD=1:
  - Addresses 0x80000000, then {L2 ppn, 9'h000, 3'b000}, then {L1 ppn, 9'h001, 3'b000}.
  - Response at T+7: error=0, ppn=0x12345, level=0.
- Level-2 PTE 0x0000_0000_2000_00CF (ppn 0x80000, leaf): response at T+3, level=2, error=0.
- Level-2 leaf with ppn 0x80001: misaligned → error=1, level=2.
- Level-1 PTE with V=0 → error=1, level=1, no further memory request.
- `csr_flush_i` in WAIT at level 1:
  - `tlb_invalidate_o` pulses one cycle later.
  - The response in flight is discarded.
  - The next memory address is the level-2 address again.
  - Exactly one `tlb_resp_valid_o` follows.
- With `PTW_AD_CHECK_EN`, store to a leaf with D=0 → error=1; without the macro, the same stimulus gives error=0.
- `rst_i` asserted in WAIT:
  - Immediately `tlb_req_ready_o`=1 and `mem_req_valid_o`=0.
  - A stale `mem_resp_valid_i` after reset produces no response.
